// File: rtl/result_readout.sv
// result_readout: sweeps accumulator BRAM rows 0..num_rows-1 and streams each row out via a 2-entry FIFO.
// Optional feature macro CLEAR_ON_READ_EN: every read is followed by a zeroing write to the same row.
module result_readout #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   num_rows,
   output logic              busy,
   output logic              done,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   input  logic [DATA_W-1:0] douta,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_row,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t            state;
   logic [ADDR_W:0]   rows_q;
   logic [ADDR_W:0]   addr_cnt;
   logic [ADDR_W:0]   addr_nxt;
   logic              armed;

   logic              rd_vld_p0;
   logic              rd_vld_p1;
   logic [ADDR_W-1:0] rd_row_p1;
   logic              clr_p1;

   logic [DATA_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_row  [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              push;
   logic              pop;
   logic [2:0]        occ;
   logic [2:0]        room;

   assign out_valid = (fifo_cnt != 2'd0);
   assign pop       = out_valid & out_ready;
   assign push      = rd_vld_p1;
   assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_row   = out_valid ? fifo_row[rd_ptr]  : '0;

   // A slot freed by this cycle's pop is credited so a full-rate stream never bubbles.
   assign occ      = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1};
   assign room     = 3'd2 + {2'b00, pop};
   assign addr_nxt = addr_cnt + {{ADDR_W{1'b0}}, 1'b1};

   // ---- p0: issue stage (read request on port A this cycle) ----
`ifdef CLEAR_ON_READ_EN
   assign clr_p1    = rd_vld_p1 & ~reset;
   assign rd_vld_p0 = (state == READ) & armed & ~rd_vld_p1 & (occ < room) & ~reset;
`else
   assign clr_p1    = 1'b0;
   assign rd_vld_p0 = (state == READ) & armed & (occ < room) & ~reset;
`endif

   always_comb begin
      ena   = rd_vld_p0 | clr_p1;
      wea   = clr_p1;
      dina  = '0;
      addra = '0;
      if (clr_p1)
         addra = rd_row_p1;
      else if (rd_vld_p0)
         addra = addr_cnt[ADDR_W-1:0];
   end

   // ---- p1: douta valid, captured into the FIFO at the end of this cycle ----
   always_ff @(posedge clk) begin
      rd_row_p1 <= addr_cnt[ADDR_W-1:0];
      if (push) begin
         fifo_data[wr_ptr] <= douta;
         fifo_row[wr_ptr]  <= rd_row_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         armed     <= 1'b0;
         rd_vld_p1 <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
         addr_cnt  <= '0;
         rows_q    <= '0;
      end else begin
         done      <= 1'b0;
         rd_vld_p1 <= rd_vld_p0;
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_rows == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state    <= READ;
                     rows_q   <= num_rows;
                     addr_cnt <= '0;
                     armed    <= 1'b0;
                  end
               end
            end
            // armed holds off the first read one cycle so the first row appears three edges after start.
            READ: begin
               armed <= 1'b1;
               if (rd_vld_p0) begin
                  addr_cnt <= addr_nxt;
                  if (addr_nxt == rows_q)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_cnt == 2'd0 && !rd_vld_p1) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/result_readout.md
RESULT_READOUT -- requirements
Module: result_readout

Interface
REQ-001 Parameter ADDR_W, 10, accumulator BRAM address width (depth 2**ADDR_W rows).
REQ-002 Parameter DATA_W, 64, accumulator word width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a readout sweep.
REQ-006 num_rows  input  ADDR_W+1  rows to read, 0..2**ADDR_W; sampled with start.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse when the sweep completes.
REQ-009 ena, wea  output  1 each  BRAM port-A enable and write enable.
REQ-010 addra  output  ADDR_W  BRAM port-A address.
REQ-011 dina  output  DATA_W  BRAM write data.
REQ-012 douta  input  DATA_W  BRAM read data, valid exactly 1 cycle after ena=1, wea=0.
REQ-013 out_data, out_row  output  DATA_W, ADDR_W  streamed accumulated value and its row index.
REQ-014 out_valid, out_ready  output, input  1 each  valid/ready stream handshake.

Function
REQ-015 FSM states: IDLE, READ, DRAIN, FINISH; the block SHALL leave IDLE only on start=1.
REQ-016 IDLE: start=1 with num_rows>0 -> READ and capture num_rows; start=1 with num_rows=0 -> FINISH, no BRAM access.
REQ-017 READ: the block SHALL issue reads to addra=0,1,...,num_rows-1 in ascending order, one per cycle, only while (output FIFO occupancy + reads in flight) < 2.
REQ-018 Each read's douta SHALL be written into a 2-entry output FIFO on the cycle after issue, tagged with its row index; no data SHALL be dropped or duplicated.
REQ-019 READ -> DRAIN after the last read is issued; DRAIN -> FINISH when the FIFO is empty and no read is in flight; FINISH pulses done for 1 cycle, then -> IDLE.
REQ-020 out_valid SHALL be high exactly when the FIFO is non-empty; a transfer occurs when out_valid=1 and out_ready=1; out_data/out_row SHALL hold steady while out_valid=1 and out_ready=0.
REQ-021 With out_ready held high, the first out_valid SHALL occur 3 cycles after the start sampling edge, and one row SHALL be delivered per cycle thereafter (CLEAR_ON_READ_EN undefined).
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 ena=0, wea=0, addra=0 and dina=0 SHALL be driven in every cycle without a BRAM access.
REQ-024 num_rows=2**ADDR_W SHALL read every row including 2**ADDR_W-1; the address counter SHALL NOT wrap.

Reset
REQ-025 reset=1 SHALL, at the next edge, force IDLE, flush the FIFO, discard in-flight reads, and drive busy=0, done=0, out_valid=0, out_data=0, out_row=0, ena=0, wea=0, addra=0, dina=0.
REQ-026 reset asserted mid-sweep SHALL abort without a done pulse; any BRAM write in that cycle SHALL be suppressed.

Configuration
REQ-027 Macro CLEAR_ON_READ_EN: when defined, each read of row r SHALL be followed on the next port cycle by a write (ena=1, wea=1, addra=r, dina=0), zeroing the accumulator for the next multiplication; rows are then issued at most every 2 cycles.
REQ-028 With CLEAR_ON_READ_EN undefined, the block SHALL never assert wea, and the BRAM contents SHALL be left unchanged.

Verification
REQ-029 BRAM rows 0..7 = 100+r, start with num_rows=8, out_ready=1 -> out_row 0..7, out_data 100..107 on consecutive cycles, first at start+3; done pulses once; busy low afterwards.
REQ-030 Same preload, out_ready toggled 1-0-0-1 repeatedly -> identical sequence, no loss or duplication, out_data stable during stalls, at most 2 reads outstanding.
REQ-031 start with num_rows=0 -> done pulses within 2 cycles, ena never asserted, out_valid never asserted.
REQ-032 num_rows=1024 with row r = r -> 1024 transfers, last out_row=1023, out_data=1023, no address wrap.
REQ-033 reset=1 for 1 cycle after 3 transfers of an 8-row sweep -> all outputs 0 next cycle, no done pulse; new start then reads from row 0.
REQ-034 CLEAR_ON_READ_EN defined, rows 0..3 = 5 -> stream yields 5,5,5,5, each read followed by wea=1 dina=0 to the same address; a second sweep yields 0,0,0,0.
